// File: rtl/pwm_compare_pkg.sv
// Shared constants and duty helpers for the
// PWM compare stage and future compare stages.
package pwm_compare_pkg;

  localparam int CNT_W = 4;
  localparam int DUTY_W = CNT_W + 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX =
    DUTY_W'(1 << CNT_W);

  // Clamp a duty request to 2^w (always-high).
  function automatic logic [31:0] sat_duty(
    input logic [31:0] d,
    input int w
  );
    logic [31:0] mx;
    mx = 32'd1 << w;
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/pwm_compare_duty_shadow.sv
// Double-buffered duty register with valid/ready
// load, wrap-aligned apply and an update pulse.
module duty_shadow
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           cnt_cout,
  input  logic [WIDTH:0] duty,
  input  logic           duty_valid,
  output logic           duty_ready,
  output logic [WIDTH:0] active_duty,
  output logic           updated
);

  localparam int DW = WIDTH + 1;

  logic [DW-1:0] pend_duty;
  logic          pend_valid;
  logic [DW-1:0] sat;
  logic          accept;

  assign sat = DW'(sat_duty(32'(duty), WIDTH));
  assign duty_ready = resetn & ~pend_valid;
  assign accept = duty_valid & duty_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_duty <= '0;
      pend_duty   <= '0;
      pend_valid  <= 1'b0;
      updated     <= 1'b0;
    end else begin
      updated <= 1'b0;
      if (cnt_cout) begin
        if (pend_valid) begin
          active_duty <= pend_duty;
          pend_valid  <= 1'b0;
          updated     <= 1'b1;
        end else if (accept) begin
          // Load on the wrap edge skips the shadow.
          active_duty <= sat;
          updated     <= 1'b1;
        end
      end else if (accept) begin
        pend_duty  <= sat;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_compare.sv
// PWM compare stage fed by a free-running counter.
// PWM_WRAP_CNT_EN adds a wrap counter on WRAP_CNT_O.
module pwm_compare
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH      = CNT_W,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [WIDTH-1:0]      CNT_I,
  input  logic                  CNT_COUT,
  input  logic [WIDTH:0]        DUTY_I,
  input  logic                  DUTY_VALID,
  output logic                  DUTY_READY,
  output logic                  PWM_O,
`ifdef PWM_WRAP_CNT_EN
  output logic [WRAP_CNT_W-1:0] WRAP_CNT_O,
`endif
  output logic                  UPDATED_O
);

  logic [WIDTH:0] active_duty;

  duty_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk        (CLK),
    .resetn     (RESETN),
    .cnt_cout   (CNT_COUT),
    .duty       (DUTY_I),
    .duty_valid (DUTY_VALID),
    .duty_ready (DUTY_READY),
    .active_duty(active_duty),
    .updated    (UPDATED_O)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      PWM_O <= 1'b0;
    end else begin
      PWM_O <= {1'b0, CNT_I} < active_duty;
    end
  end

`ifdef PWM_WRAP_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      WRAP_CNT_O <= '0;
    end else if (CNT_COUT) begin
      WRAP_CNT_O <= WRAP_CNT_O + 1'b1;
    end
  end
`else
  localparam int unused_wrap_w = WRAP_CNT_W;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Bench for pwm_compare: queue-based duty model
// against a free-running 4-bit counter.
module tb_pwm_compare;
  import pwm_compare_pkg::*;

  logic       CLK;
  logic       RESETN;
  logic [3:0] CNT_I;
  logic       CNT_COUT;
  logic [4:0] DUTY_I;
  logic       DUTY_VALID;
  logic       DUTY_READY;
  logic       PWM_O;
  logic       UPDATED_O;
`ifdef PWM_WRAP_CNT_EN
  logic [7:0] WRAP_CNT_O;
`endif

  pwm_compare #(.WIDTH(4), .WRAP_CNT_W(8)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .CNT_I     (CNT_I),
    .CNT_COUT  (CNT_COUT),
    .DUTY_I    (DUTY_I),
    .DUTY_VALID(DUTY_VALID),
    .DUTY_READY(DUTY_READY),
    .PWM_O     (PWM_O),
`ifdef PWM_WRAP_CNT_EN
    .WRAP_CNT_O(WRAP_CNT_O),
`endif
    .UPDATED_O (UPDATED_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  int cnt;
  int m_active;
  int pend_q[$];
  int m_wrap;
  bit e_pwm, e_upd, e_ready, last_acc;

  // One clock: drive inputs, update the model,
  // then advance the free-running counter.
  task automatic tick(input bit v, input int d,
                      input bit rn);
    bit rdy, cout;
    int sat;
    DUTY_VALID = v;
    DUTY_I = d[4:0];
    RESETN = rn;
    rdy = rn && pend_q.size() == 0;
    sat = (d > int'(DUTY_MAX)) ? int'(DUTY_MAX) : d;
    cout = (cnt == 15);
    @(posedge CLK);
    last_acc = v && rdy;
    if (!rn) begin
      m_active = 0;
      pend_q.delete();
      e_pwm = 0;
      e_upd = 0;
      m_wrap = 0;
    end else begin
      e_pwm = cnt < m_active;
      e_upd = 0;
      if (last_acc) pend_q.push_back(sat);
      if (cout && pend_q.size() > 0) begin
        m_active = pend_q.pop_front();
        e_upd = 1;
      end
      if (cout) m_wrap = (m_wrap + 1) % 256;
    end
    #1;
    e_ready = rn && pend_q.size() == 0;
    cnt = (cnt + 1) % 16;
    CNT_I = cnt[3:0];
    CNT_COUT = (cnt == 15);
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 16 && cnt != c; i++)
      tick(0, 0, 1);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      n_checks++;
      if (DUTY_READY !== 1'b0 || PWM_O !== 1'b0 ||
          UPDATED_O !== 1'b0)
        $display("FAIL reset rdy=%b pwm=%b upd=%b req 0",
                 DUTY_READY, PWM_O, UPDATED_O);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      tick(0, 0, 1);
      n_checks++;
      if (PWM_O !== 1'b0 || DUTY_READY !== 1'b1 ||
          UPDATED_O !== 1'b0)
        $display("FAIL post_reset i=%0d pwm=%b rdy=%b upd=%b req 0/1/0",
                 i, PWM_O, DUTY_READY, UPDATED_O);
      else n_pass++;
    end
  endtask

  task automatic test_load;
    int highs;
    run_to(7);
    tick(1, 5, 1);
    n_checks++;
    if (DUTY_READY !== 1'b0)
      $display("FAIL load_ready got %b req 0", DUTY_READY);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1);
      n_checks++;
      if (UPDATED_O !== (i == 7) ||
          DUTY_READY !== (i == 7))
        $display("FAIL load_wait i=%0d upd=%b rdy=%b req %b",
                 i, UPDATED_O, DUTY_READY, i == 7);
      else n_pass++;
    end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1);
      highs += int'(PWM_O);
      n_checks++;
      if (PWM_O !== (i < 5))
        $display("FAIL load_pwm i=%0d got %b req %b",
                 i, PWM_O, i < 5);
      else n_pass++;
    end
    n_checks++;
    if (highs != 5)
      $display("FAIL load_highs got %0d req 5", highs);
    else n_pass++;
  endtask

  task automatic test_bypass;
    run_to(15);
    tick(1, 3, 1);
    n_checks++;
    if (DUTY_READY !== 1'b1 || UPDATED_O !== 1'b1)
      $display("FAIL bypass rdy=%b upd=%b req 1/1",
               DUTY_READY, UPDATED_O);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1);
      n_checks++;
      if (PWM_O !== (i < 3) || DUTY_READY !== 1'b1)
        $display("FAIL bypass_pwm i=%0d got %b req %b",
                 i, PWM_O, i < 3);
      else n_pass++;
    end
  endtask

  task automatic test_saturate;
    int ds[3] = '{16, 31, 0};
    for (int k = 0; k < 3; k++) begin
      run_to(15);
      tick(1, ds[k], 1);
      for (int i = 0; i < 16; i++) begin
        tick(0, 0, 1);
        n_checks++;
        if (PWM_O !== (ds[k] != 0))
          $display("FAIL sat d=%0d i=%0d got %b req %b",
                   ds[k], i, PWM_O, ds[k] != 0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_pending;
    run_to(3);
    tick(1, 9, 1);
    n_checks++;
    if (DUTY_READY !== 1'b0)
      $display("FAIL pend_ready got %b req 0", DUTY_READY);
    else n_pass++;
    run_to(10);
    tick(0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      tick(0, 0, 1);
      n_checks++;
      if (PWM_O !== 1'b0 || UPDATED_O !== 1'b0 ||
          DUTY_READY !== 1'b1)
        $display("FAIL pend_rst i=%0d pwm=%b upd=%b rdy=%b req 0/0/1",
                 i, PWM_O, UPDATED_O, DUTY_READY);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    bit hv = 0;
    int hd = 0;
    bit rn;
    for (int i = 0; i < 500; i++) begin
      if (!hv && $urandom_range(1, 0) == 1) begin
        hv = 1;
        hd = int'($urandom_range(31, 0));
      end
      rn = $urandom_range(79, 0) != 0;
      tick(hv, hd, rn);
      if (last_acc) hv = 0;
      n_checks++;
      if (PWM_O !== e_pwm || UPDATED_O !== e_upd ||
          DUTY_READY !== e_ready)
        $display("FAIL rand i=%0d pwm=%b upd=%b rdy=%b req %b/%b/%b",
                 i, PWM_O, UPDATED_O, DUTY_READY,
                 e_pwm, e_upd, e_ready);
      else n_pass++;
    end
  endtask

`ifdef PWM_WRAP_CNT_EN
  task automatic test_wrap_cnt;
    tick(0, 0, 0);
    for (int i = 0; i < 259 * 16; i++) tick(0, 0, 1);
    n_checks++;
    if (WRAP_CNT_O !== 8'd3 || m_wrap != 3)
      $display("FAIL wrap_cnt got %0d req 3", WRAP_CNT_O);
    else n_pass++;
    tick(0, 0, 0);
    n_checks++;
    if (WRAP_CNT_O !== 8'd0)
      $display("FAIL wrap_rst got %0d req 0", WRAP_CNT_O);
    else n_pass++;
  endtask
`endif

  initial begin
    RESETN = 1'b0;
    DUTY_VALID = 1'b0;
    DUTY_I = '0;
    m_active = 0;
    m_wrap = 0;
    cnt = int'($urandom_range(15, 0));
    CNT_I = cnt[3:0];
    CNT_COUT = (cnt == 15);
    test_reset();
    test_load();
    test_bypass();
    test_saturate();
    test_reset_pending();
    test_random();
`ifdef PWM_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
